up_dn_counter: RTL and testbench



---
 rtl/up_dn_counter_pkg.sv | 6 +
 rtl/up_dn_counter_if.sv | 13 +
 rtl/up_dn_counter.sv | 28 ++
 tb/tb_up_dn_counter.sv | 93 +++++++++
 4 files changed

// File: rtl/up_dn_counter_pkg.sv
// up_dn_counter_pkg: width, limit and count type shared by the counter and its interface
package up_dn_counter_pkg;
    localparam int WIDTH = 5;
    typedef logic [WIDTH-1:0] count_t;
    localparam count_t MAX = '1;
endpackage

// File: rtl/up_dn_counter_if.sv
// up_dn_counter_if: control inputs and count/flag outputs of the saturating counter
interface up_dn_counter_if;
    import up_dn_counter_pkg::*;
    count_t IN;
    logic   Load;
    logic   Up;
    logic   Down;
    count_t Counter;
    logic   High;
    logic   Low;
    modport master (output IN, Load, Up, Down, input Counter, High, Low);
    modport slave  (input IN, Load, Up, Down, output Counter, High, Low);
endinterface

// File: rtl/up_dn_counter.sv
// up_dn_counter: saturating up/down counter with parallel load and terminal-value flags
module up_dn_counter
    import up_dn_counter_pkg::*;
(
    input logic             CLK,
    input logic             RST,
    up_dn_counter_if.slave  bus
);
    count_t counter_q, counter_d;
    // next count: load beats down, down beats up; both directions clamp instead of wrapping
    always_comb begin
        counter_d = bus.Load ? bus.IN
                  : bus.Down ? (counter_q != '0 ? counter_q - count_t'(1) : counter_q)
                  : bus.Up ? (counter_q != MAX ? counter_q + count_t'(1) : counter_q)
                  : counter_q;
    end
    // count register, cleared the moment reset rises
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) counter_q <= '0;
        else     counter_q <= counter_d;
    end
    // flags decode the register directly so they line up with the count they describe
    always_comb begin
        bus.Counter = counter_q;
        bus.High    = counter_q == MAX;
        bus.Low     = counter_q == '0;
    end
endmodule

// File: tb/tb_up_dn_counter.sv
// tb_up_dn_counter: directed and random stimulus with a queued reference count
module tb_up_dn_counter;
    import up_dn_counter_pkg::*;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    up_dn_counter_if bus();
    up_dn_counter dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;
    int checks = 0;
    int errors = 0;
    count_t model = '0;
    count_t sb[$];

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input count_t e);
        chk({tag, "_cnt"}, bus.Counter, e);
        chk({tag, "_high"}, {4'b0, bus.High}, {4'b0, e == 5'd31});
        chk({tag, "_low"}, {4'b0, bus.Low}, {4'b0, e == 5'd0});
    endtask

    task automatic step(input string tag, input logic ld, input logic up, input logic dn, input count_t in_v);
        count_t e;
        bus.Load = ld;
        bus.Up   = up;
        bus.Down = dn;
        bus.IN   = in_v;
        if (ld)      model = in_v;
        else if (dn) model = (model == 5'd0) ? model : model - count_t'(1);
        else if (up) model = (model == 5'd31) ? model : model + count_t'(1);
        sb.push_back(model);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk_all(tag, e);
    endtask

    initial begin
        bus.IN = '0; bus.Load = 1'b0; bus.Up = 1'b1; bus.Down = 1'b0;
        #1 RST = 1'b1;
        #1 chk_all("rst_async", 5'd0);
        repeat (2) @(posedge CLK);
        #1 chk_all("rst_held", 5'd0);
        RST = 1'b0;
        #1 chk_all("rst_after", 5'd0);
        bus.Up = 1'b0;
        model = '0;
        @(posedge CLK);
        #1 chk_all("idle", 5'd0);
        step("load3", 1, 0, 0, 5'd3);
        chk("load3_const", bus.Counter, 5'd3);
        step("prio_ud", 0, 1, 1, 5'd0);
        chk("prio_ud_const", bus.Counter, 5'd2);
        step("up_only", 0, 1, 0, 5'd0);
        chk("up_only_const", bus.Counter, 5'd3);
        step("load17", 1, 1, 0, 5'd17);
        chk("load17_const", bus.Counter, 5'd17);
        step("reload3", 1, 0, 0, 5'd3);
        for (int i = 0; i < 5; i++) begin
            step("down_sat", 0, 0, 1, 5'd0);
            if (i == 2) chk("down_reach0", bus.Counter, 5'd0);
        end
        chk("down_hold0", {4'b0, bus.Low}, 5'd1);
        for (int i = 0; i < 35; i++) begin
            step("up_sat", 0, 1, 0, 5'd0);
            if (i == 30) chk("up_reach31", bus.Counter, 5'd31);
        end
        chk("up_hold31", bus.Counter, 5'd31);
        step("load31_up", 1, 1, 0, 5'd31);
        step("load0_dn", 1, 0, 1, 5'd0);
        step("load20", 1, 0, 0, 5'd20);
        chk("load20_const", bus.Counter, 5'd20);
        bus.Load = 1'b0;
        bus.Up = 1'b1;
        #2 RST = 1'b1;
        #1 chk_all("mid_rst", 5'd0);
        model = '0;
        #1 RST = 1'b0;
        step("post_rst_up", 0, 1, 0, 5'd0);
        chk("post_rst_const", bus.Counter, 5'd1);
        for (int i = 0; i < 80; i++)
            step("rand", ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom_range(0, 2) == 0), count_t'($urandom));
        chk("sb_empty", 5'(sb.size()), 5'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
